// File: rtl/secuenciador_mac_pkg.sv
// Shared constants for the FIR MAC sequencer: Q(M.F) word format, tap count
// and the saturation limits used by the multiplier and the accumulator.
package secuenciador_mac_pkg;
  localparam int N    = 16;
  localparam int M    = 7;
  localparam int F    = 8;
  localparam int TAPS = 4;
  localparam int AW   = 2;

  localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
endpackage

// File: rtl/secuenciador_mac_mult_sat.sv
// Combinational N x N signed multiply, arithmetic shift by F and saturation
// of the result back into the N-bit signed range.
module mult_sat
  import secuenciador_mac_pkg::*;
(
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  logic signed [2*N-1:0] p;

  // Dropped fraction bits are simply discarded, so results floor toward -inf.
  function automatic logic [N-1:0] sat_trunc(input logic signed [2*N-1:0] v);
    logic signed [2*N-1:0] s;
    s = v >>> F;
    if (s[2*N-1:N-1] != {(N+1){s[2*N-1]}})
      sat_trunc = v[2*N-1] ? SAT_MIN : SAT_MAX;
    else
      sat_trunc = s[N-1:0];
  endfunction

  assign p = (2*N)'($signed(a)) * (2*N)'($signed(b));
  assign y = sat_trunc(p);

endmodule

// File: rtl/secuenciador_mac.sv
// Sequential TAPS-tap FIR: one shared multiplier walks the delay line against
// an external asynchronous coefficient ROM, accumulating with saturation.
module secuenciador_mac
  import secuenciador_mac_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  x_in,
  output logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_data,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  y_out
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ACC, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       k;
  logic signed [N-1:0] xd [TAPS];
  logic signed [N-1:0] xin_p0;
  logic signed [N-1:0] prod, preg_p1, acc_p2;
  logic                last;

  function automatic logic signed [N-1:0] satadd(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = {a[N-1], a} + {b[N-1], b};
    if (s[N] != s[N-1])
      satadd = s[N] ? SAT_MIN : SAT_MAX;
    else
      satadd = s[N-1:0];
  endfunction

  assign last = (k == AW'(TAPS-1));

  mult_sat u_mult (
    .a (coef_data),
    .b (xd[k]),
    .y (prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_MUL;
      S_MUL:   state_nxt = S_ACC;
      S_ACC:   state_nxt = last ? S_DONE : S_MUL;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    coef_addr = k;
  end

  // Datapath: the sample is captured when start is accepted and enters the
  // delay line in LOAD; y_out and the done pulse are registered out of DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k       <= '0;
      xin_p0  <= '0;
      preg_p1 <= '0;
      acc_p2  <= '0;
      y_out   <= '0;
      done    <= 1'b0;
      for (int i = 0; i < TAPS; i++) xd[i] <= '0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: if (start) xin_p0 <= x_in;
        S_LOAD: begin
          xd[0] <= xin_p0;
          for (int i = 1; i < TAPS; i++) xd[i] <= xd[i-1];
          acc_p2 <= '0;
          k      <= '0;
        end
        S_MUL:  preg_p1 <= prod;
        S_ACC: begin
          acc_p2 <= satadd(acc_p2, preg_p1);
          if (!last) k <= k + 1'b1;
        end
        S_DONE: begin
          y_out <= acc_p2;
          k     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_mac.sv
// Self-checking bench for secuenciador_mac: directed scenarios plus random
// samples/coefficients compared against a plain-arithmetic FIR model.
module tb_secuenciador_mac;
  logic        clk = 1'b0;
  logic        reset, start, busy, done;
  logic [15:0] x_in, coef_data, y_out;
  logic [1:0]  coef_addr;
  logic [15:0] rom [4];
  logic signed [15:0] mh [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign coef_data = rom[coef_addr];

  secuenciador_mac dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy),
    .done      (done),
    .y_out     (y_out)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mh[i] = 16'sd0;
  endtask

  task automatic model_push(input logic [15:0] x);
    for (int i = 3; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = x;
  endtask

  function automatic logic [15:0] model_y();
    longint acc, p;
    acc = 0;
    for (int t = 0; t < 4; t++) begin
      p = longint'($signed(rom[t])) * longint'(mh[t]);
      p = p >>> 8;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      acc = acc + p;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
    end
    return acc[15:0];
  endfunction

  task automatic run(input logic [15:0] x, output logic [15:0] y, output int lat,
                     output bit addr_ok, output bit pulse_ok);
    y = 'x; lat = -1; addr_ok = 1'b1; pulse_ok = 1'b0;
    @(negedge clk); x_in = x; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; x_in = 16'($urandom);
    if (!busy || coef_addr != 2'd0) addr_ok = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if ((c % 2 == 1) && c < 8 && coef_addr != 2'((c-1)/2)) addr_ok = 1'b0;
      if (done) begin lat = c; y = y_out; break; end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_ok = !done && !busy && coef_addr == 2'd0 && y_out == y;
    end
  endtask

  task automatic test_reset();
    logic [15:0] y; int lat; bit a_ok, p_ok;
    #2 reset = 1'b1; #1;
    checks++; if (y_out !== 16'h0) begin errors++; $display("FAIL reset_y got %h exp 0000", y_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || coef_addr !== 2'd0) begin
      errors++; $display("FAIL reset_ctl got busy=%b done=%b addr=%0d exp 0 0 0", busy, done, coef_addr); end
    @(negedge clk); reset = 1'b0; model_reset();
    rom[0] = 16'h0100; rom[1] = 16'h0200; rom[2] = 16'h0300; rom[3] = 16'h0400;
    run(16'h0200, y, lat, a_ok, p_ok); model_push(16'h0200);
    checks++; if (y !== model_y()) begin errors++; $display("FAIL pre_reset_y got %h exp %h", y, model_y()); end
    @(negedge clk); x_in = 16'h0005; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1; #1;
    checks++; if (y_out !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || coef_addr !== 2'd0) begin
      errors++; $display("FAIL async_reset got y=%h busy=%b done=%b addr=%0d exp 0", y_out, busy, done, coef_addr); end
    @(negedge clk); reset = 1'b0; model_reset();
  endtask

  task automatic test_impulse();
    logic [15:0] y, exp_tab [4]; int lat; bit a_ok, p_ok;
    rom[0] = 16'h0080; rom[1] = 16'h0040; rom[2] = 16'hFFC0; rom[3] = 16'h0100;
    exp_tab[0] = 16'h0080; exp_tab[1] = 16'h0040; exp_tab[2] = 16'hFFC0; exp_tab[3] = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      run((i == 0) ? 16'h0100 : 16'h0000, y, lat, a_ok, p_ok);
      checks++; if (y !== exp_tab[i]) begin errors++; $display("FAIL impulse_y%0d got %h exp %h", i, y, exp_tab[i]); end
      checks++; if (lat != 10) begin errors++; $display("FAIL impulse_lat%0d got %0d exp 10", i, lat); end
      checks++; if (!a_ok) begin errors++; $display("FAIL impulse_addr%0d got bad exp 0,1,2,3", i); end
      checks++; if (!p_ok) begin errors++; $display("FAIL impulse_pulse%0d got bad exp one-cycle", i); end
    end
    for (int i = 0; i < 4; i++) model_push((i == 0) ? 16'h0100 : 16'h0000);
  endtask

  task automatic test_saturation();
    logic [15:0] y; int lat; bit a_ok, p_ok;
    for (int i = 0; i < 4; i++) rom[i] = 16'h7FFF;
    for (int i = 0; i < 4; i++) begin
      run(16'h7FFF, y, lat, a_ok, p_ok); model_push(16'h7FFF);
      checks++; if (y !== 16'h7FFF || y !== model_y()) begin
        errors++; $display("FAIL pos_sat%0d got %h exp 7fff", i, y); end
    end
    for (int i = 0; i < 4; i++) rom[i] = 16'h8000;
    run(16'h7FFF, y, lat, a_ok, p_ok); model_push(16'h7FFF);
    checks++; if (y !== 16'h8000 || y !== model_y()) begin
      errors++; $display("FAIL neg_sat got %h exp 8000", y); end
  endtask

  task automatic test_trunc();
    logic [15:0] y; int lat; bit a_ok, p_ok;
    rom[0] = 16'h0001; rom[1] = 16'h0; rom[2] = 16'h0; rom[3] = 16'h0;
    run(16'h0180, y, lat, a_ok, p_ok); model_push(16'h0180);
    checks++; if (y !== 16'h0001) begin errors++; $display("FAIL trunc_pos got %h exp 0001", y); end
    run(16'hFE80, y, lat, a_ok, p_ok); model_push(16'hFE80);
    checks++; if (y !== 16'hFFFE) begin errors++; $display("FAIL trunc_neg got %h exp fffe", y); end
  endtask

  task automatic test_random();
    logic [15:0] y, x; int lat; bit a_ok, p_ok;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++)
        rom[i] = (s == 0) ? 16'($signed(12'($urandom))) : 16'($urandom);
      for (int r = 0; r < 6; r++) begin
        x = 16'($urandom);
        run(x, y, lat, a_ok, p_ok); model_push(x);
        checks++; if (y !== model_y() || lat != 10) begin
          errors++; $display("FAIL random_s%0d_r%0d got %h lat %0d exp %h lat 10", s, r, y, lat, model_y()); end
      end
    end
  endtask

  task automatic test_protocol();
    logic [15:0] y, x; int lat, ndone, first; bit a_ok, p_ok;
    rom[0] = 16'h1234; rom[1] = 16'h0300; rom[2] = 16'hFD00; rom[3] = 16'h0150;
    x = 16'h0123; ndone = 0; first = -1; y = 'x;
    @(negedge clk); x_in = x; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; if (first < 0) begin first = c; y = y_out; end end
      @(negedge clk);
      start = (c == 3 || c == 9); x_in = 16'($urandom);
    end
    model_push(x);
    checks++; if (ndone != 1 || first != 10) begin
      errors++; $display("FAIL ignore_start got dones=%0d at %0d exp 1 at 10", ndone, first); end
    checks++; if (y !== model_y()) begin errors++; $display("FAIL ignore_y got %h exp %h", y, model_y()); end
    run(16'h0040, y, lat, a_ok, p_ok); model_push(16'h0040);
    checks++; if (y !== model_y()) begin errors++; $display("FAIL line_intact got %h exp %h", y, model_y()); end
    @(negedge clk); x_in = 16'h0777; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_in_acc got busy=%b done=%b exp 0 0", busy, done); end
    repeat (2) @(negedge clk);
    reset = 1'b0; model_reset(); ndone = 0;
    for (int c = 0; c < 15; c++) begin @(posedge clk); #1; if (done) ndone++; end
    checks++; if (ndone != 0) begin errors++; $display("FAIL no_done_after_reset got %0d exp 0", ndone); end
    run(16'h0100, y, lat, a_ok, p_ok); model_push(16'h0100);
    checks++; if (y !== 16'h1234 || y !== model_y()) begin
      errors++; $display("FAIL line_cleared got %h exp 1234", y); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; x_in = '0;
    for (int i = 0; i < 4; i++) rom[i] = '0;
    model_reset();
    test_reset();
    test_impulse();
    test_saturation();
    test_trunc();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/secuenciador_mac.md
Name: secuenciador_mac

Overview:
- Sequential controller for a single shared fixed-point multiply/truncate/accumulate datapath, implementing a TAPS-tap FIR filter.
- Each start pulse latches a new sample and shifts the delay line.
- It then steps through all taps, fetching one coefficient per tap from an external coefficient ROM.
- Each product is saturate-truncated to N bits and added into a saturating accumulator; the filter output is presented with a one-cycle done pulse.
- Sits between the sample source (ADC/serial receiver) and the output register/DAC interface.

Parameters:
- N, 16 (from `N): total word width, signed Q(M.F) with one sign bit; N = 1+M+F.
- M, 7 (from `M): integer bits.
- F, 8 (from `F): fraction bits.
- TAPS, 4: number of filter taps, at least 2.
- AW, 2: coefficient address width, equal to clog2(TAPS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to process x_in; sampled only in IDLE.
- x_in  in  N  signed input sample.
- coef_addr  out  AW  coefficient ROM address, combinational from the tap counter.
- coef_data  in  N  signed coefficient; valid in the same cycle as coef_addr (asynchronous ROM).
- busy  out  1  high from the cycle after start is accepted through DONE inclusive.
- done  out  1  one-cycle pulse; y_out is valid from this cycle onward.
- y_out  out  N  signed filter output, held until the next done.

Behaviour:
- Reset: asynchronous and active-high, so it takes effect immediately regardless of clk.
  - Outputs: y_out=0, done=0, busy=0, coef_addr=0.
  - Internal: FSM=IDLE, tap counter k=0, accumulator=0, all TAPS delay-line registers=0.
- FSM states: IDLE, LOAD, MUL, ACC, DONE.
  - IDLE: when start=1, go to LOAD. Otherwise hold.
  - LOAD: shift the delay line (x[TAPS-1] <- x[TAPS-2] ... x[0] <- x_in, with x_in captured on the accepting edge). Clear the accumulator, set k=0, go to MUL.
  - MUL: p = coef_data * x[k], full 2N-bit signed product. Register trunc(p) into the product register. Go to ACC.
  - ACC: acc = satadd(acc, preg). If k==TAPS-1 go to DONE; else k=k+1 and go to MUL.
  - DONE: y_out <= acc, done=1 for this cycle only. Go to IDLE.
- Latency: done is high exactly 2*TAPS+2 cycles after the edge that samples start (10 cycles for TAPS=4). Throughput is one sample per 2*TAPS+3 cycles.
- trunc(p):
  - Arithmetic shift right by F.
  - If bits above the N-bit signed range are not all copies of the sign bit, saturate: +max = 2^(N-1)-1 when p>0, -min = -2^(N-1) when p<0.
  - Discarded fraction bits are truncated (toward minus infinity); no rounding.
- satadd: (N+1)-bit sum, clamped to [-2^(N-1), 2^(N-1)-1].
- start while busy is ignored; it is not queued. busy is still 1 in DONE, so a start in DONE is also ignored.
- coef_addr equals k in every state; it is 0 in IDLE and LOAD.
- y_out changes only in DONE.
- Reset mid-operation: the computation is abandoned immediately, no done is issued, and all state returns to reset values, including the delay line.

Decomposition:
- Shared header (existing constants header): N, M, F, TAPS, AW, and the saturation limits SAT_MAX/SAT_MIN.
- FSM state encoding is local to the module.
- One natural sub-module: mult_sat, a combinational N x N signed multiply plus saturating truncation to N bits. The FSM/accumulator stays in secuenciador_mac.

Test Plan:
1. Reset behaviour: assert reset mid-cycle with no clock edge -> y_out=0, busy=0, done=0, coef_addr=0 immediately.
2. Impulse response:
   - Stimulus: coef = {0x0080, 0x0040, 0xFFC0, 0x0100} (0.5, 0.25, -0.25, 1.0). Start with x=0x0100, then three starts with x=0.
   - Required response: y_out = 0x0080, 0x0040, 0xFFC0, 0x0100 in order. Each done arrives exactly 10 cycles after its start, with coef_addr sequence 0,1,2,3 in MUL.
3. Positive saturation: all coef=0x7FFF, x=0x7FFF -> each product and the accumulator saturate, y_out=0x7FFF.
4. Negative saturation: all coef=0x8000, x=0x7FFF -> y_out=0x8000.
5. Truncation and accumulation: coef[0]=0x0001, others 0, x=0x0180 (1.5) -> y_out=0x0001. Same setup with x=0xFE80 (-1.5) -> y_out=0xFFFE (floor behaviour).
6. Protocol:
   - start pulses during MUL and during DONE are ignored: no extra done, delay line unchanged.
   - Reset asserted in ACC of tap 2 -> busy drops immediately, no done. After release, start with x=0x0100 yields y_out=coef[0]*1.0 only, confirming the delay line was cleared.
